// File: rtl/adder_acc_pkg.sv
// Shared types and constants for the adder result accumulator.
// The beat is the 4-bit ripple-carry sum with its carry as bit 4.
package adder_acc_pkg;

  localparam int SUM_W  = 4;
  localparam int BEAT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [BEAT_W-1:0] beat_value(input logic carry,
                                                   input logic [SUM_W-1:0] s);
    return {carry, s};
  endfunction

endpackage

// File: rtl/adder_result_accumulator.sv
// Accumulates BURST_LEN adder results into one total with an overflow flag.
// Optional macro ACC_SATURATE_EN: clamp the total at full scale instead of wrapping.
module adder_result_accumulator
  import adder_acc_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  input  logic             carry_out,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ovf_r, ovf_s;
  logic             in_ready_r, out_valid_r, out_ovf_r;
  logic [ACC_W-1:0] out_total_r;
  logic [ACC_W:0]   beat_ext_s;
  logic [ACC_W:0]   sum_ext_s;
  logic [ACC_W-1:0] acc_new_s;
  logic             ovf_hit_s;
  logic             accept_s;

  assign beat_ext_s = {{(ACC_W + 1 - BEAT_W){1'b0}}, beat_value(carry_out, sum)};
  assign accept_s   = in_valid & in_ready_r;

  // Next accumulator value and overflow detection for an accepted beat.
  always_comb begin
    if (state_r == ACCUM) begin
      sum_ext_s = {1'b0, acc_r} + beat_ext_s;
    end else begin
      sum_ext_s = beat_ext_s;
    end
    ovf_hit_s = sum_ext_s[ACC_W];
`ifdef ACC_SATURATE_EN
    if (ovf_hit_s) begin
      acc_new_s = ACC_MAX;
    end else begin
      acc_new_s = sum_ext_s[ACC_W-1:0];
    end
`else
    acc_new_s = sum_ext_s[ACC_W-1:0];
`endif
  end

  // Burst FSM next-state and datapath update; clr overrides everything.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          acc_s   = acc_new_s;
          cnt_s   = CNT_W'(1);
          ovf_s   = ovf_hit_s;
          state_s = (BURST_LEN == 1) ? HOLD : ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_s = acc_new_s;
          cnt_s = cnt_r + CNT_W'(1);
          ovf_s = ovf_r | ovf_hit_s;
          if (cnt_r == LAST_CNT) begin
            state_s = HOLD;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          ovf_s   = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = {ACC_W{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
        ovf_s   = 1'b0;
      end
    endcase
    if (clr) begin
      state_s = IDLE;
      acc_s   = {ACC_W{1'b0}};
      cnt_s   = {CNT_W{1'b0}};
      ovf_s   = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, datapath and registered output decode (outputs follow next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_total_r <= {ACC_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      in_ready_r  <= (state_s != HOLD);
      out_valid_r <= (state_s == HOLD);
      out_total_r <= (state_s == HOLD) ? acc_s : {ACC_W{1'b0}};
      out_ovf_r   <= (state_s == HOLD) ? ovf_s : 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_total = out_total_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench: an ACC_W=8 instance for the main scenarios plus an ACC_W=6
// instance sharing the same stimulus for the overflow scenario.
module tb_adder_result_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] sum;
  logic       carry_out;
  logic       clr;
  logic       out_ready;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_total;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_total6;
  int         checks;
  int         errors;

  adder_result_accumulator #(.ACC_W(8), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry_out(carry_out), .clr(clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_total(out_total), .out_ovf(out_ovf)
  );

  adder_result_accumulator #(.ACC_W(6), .BURST_LEN(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
    .sum(sum), .carry_out(carry_out), .clr(clr), .out_valid(out_valid6),
    .out_ready(out_ready), .out_total(out_total6), .out_ovf(out_ovf6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] s, input logic c);
    in_valid  = 1'b1;
    sum       = s;
    carry_out = c;
    step();
  endtask

  task automatic consume();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_total !== 8'd0) begin errors++; $display("FAIL reset_total got %0d want 0", out_total); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_held_ready got %b want 0", in_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    beat(4'd11, 1'b0); beat(4'd13, 1'b0); beat(4'd14, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    beat(4'd11, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_total !== 8'd49) begin errors++; $display("FAIL basic_total got %0d want 49", out_total); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got %b want 0", in_ready); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed_valid got %b want 0", out_valid); end
    checks++; if (out_total !== 8'd0) begin errors++; $display("FAIL basic_consumed_total got %0d want 0", out_total); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_consumed_ready got %b want 1", in_ready); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp6;
`ifdef ACC_SATURATE_EN
    exp6 = 6'd63;
`else
    exp6 = 6'd60;
`endif
    for (int i = 0; i < 4; i++) beat(4'd15, 1'b1);
    in_valid = 1'b0;
    checks++; if (out_total !== 8'd124) begin errors++; $display("FAIL ovf_w8_total got %0d want 124", out_total); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_w8_flag got %b want 0", out_ovf); end
    checks++; if (out_valid6 !== 1'b1) begin errors++; $display("FAIL ovf_w6_valid got %b want 1", out_valid6); end
    checks++; if (out_total6 !== exp6) begin errors++; $display("FAIL ovf_w6_total got %0d want %0d", out_total6, exp6); end
    checks++; if (out_ovf6 !== 1'b1) begin errors++; $display("FAIL ovf_w6_flag got %b want 1", out_ovf6); end
    consume();
    checks++; if (out_ovf6 !== 1'b0) begin errors++; $display("FAIL ovf_w6_cleared got %b want 0", out_ovf6); end
  endtask

  task automatic test_hold_stall();
    beat(4'd11, 1'b0); beat(4'd13, 1'b0); beat(4'd14, 1'b0); beat(4'd11, 1'b0);
    sum = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== 8'd49)
        begin errors++; $display("FAIL stall_cycle%0d got ready=%b valid=%b total=%0d want 0 1 49", i, in_ready, out_valid, out_total); end
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL stall_release got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    for (int i = 0; i < 4; i++) beat(4'd2, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_total !== 8'd8) begin errors++; $display("FAIL stall_no_accept_total got %0d want 8", out_total); end
    consume();
  endtask

  task automatic test_gaps();
    beat(4'd11, 1'b0); in_valid = 1'b0; step(); step();
    beat(4'd13, 1'b0); in_valid = 1'b0; step(); step();
    beat(4'd14, 1'b0); in_valid = 1'b0; step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got %b want 0", out_valid); end
    beat(4'd11, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_total !== 8'd49)
      begin errors++; $display("FAIL gaps_total got valid=%b total=%0d want 1 49", out_valid, out_total); end
    consume();
  endtask

  task automatic test_clr();
    beat(4'd3, 1'b0); beat(4'd3, 1'b0);
    clr = 1'b1;
    beat(4'd3, 1'b0);
    clr = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL clr_idle got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) beat(4'd5, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_early_valid got %b want 0", out_valid); end
    beat(4'd5, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_total !== 8'd20)
      begin errors++; $display("FAIL clr_total got valid=%b total=%0d want 1 20", out_valid, out_total); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_total !== 8'd0)
      begin errors++; $display("FAIL clr_in_hold got valid=%b total=%0d want 0 0", out_valid, out_total); end
  endtask

  task automatic test_reset_mid();
    beat(4'd9, 1'b0); beat(4'd9, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_total !== 8'd0 || out_ovf !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got ready=%b valid=%b total=%0d ovf=%b want 0 0 0 0", in_ready, out_valid, out_total, out_ovf); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) beat(4'd1, 1'b0);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_total !== 8'd4)
      begin errors++; $display("FAIL rstmid_total got valid=%b total=%0d want 1 4", out_valid, out_total); end
    consume();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum       = 4'd0;
    carry_out = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_hold_stall();
    test_gaps();
    test_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

Interface
REQ-001 Parameter ACC_W, default 8, accumulator and total width (>= 6).
REQ-002 Parameter BURST_LEN, default 4, beats per burst (>= 1).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream adder result valid.
REQ-006 in_ready  output  1  block can accept a beat.
REQ-007 sum  input  4  ripple-carry adder sum.
REQ-008 carry_out  input  1  ripple-carry adder carry.
REQ-009 clr  input  1  synchronous burst abort.
REQ-010 out_valid  output  1  burst total available.
REQ-011 out_ready  input  1  downstream accepts total.
REQ-012 out_total  output  ACC_W  accumulated burst total.
REQ-013 out_ovf  output  1  total exceeded ACC_W range during burst.

Function
REQ-014 Beat value SHALL be {carry_out, sum}, 5 bits (0..31), zero-extended to ACC_W+1 bits before addition.
REQ-015 A beat SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-016 FSM states SHALL be IDLE, ACCUM, HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 IDLE: on accept, acc <= value, cnt <= 1, next = HOLD if BURST_LEN==1 else ACCUM.
REQ-018 ACCUM: on accept, acc <= acc+value, cnt <= cnt+1; next = HOLD when the accepted beat is beat BURST_LEN.
REQ-019 ACCUM with no accept: acc, cnt, state unchanged (bubbles allowed, no timeout).
REQ-020 HOLD: out_valid=1, out_total=acc, out_ovf=sticky flag; all stable while out_ready=0.
REQ-021 HOLD with out_ready=1: next = IDLE, acc, cnt, ovf cleared; no beat accepted that cycle.
REQ-022 Latency: out_valid SHALL assert the cycle after the last beat is accepted.
REQ-023 out_valid=0 and out_total=0, out_ovf=0 outside HOLD.
REQ-024 Overflow: when the (ACC_W+1)-bit sum exceeds 2^ACC_W-1, ovf SHALL set and stay set until the burst is consumed or cleared.
REQ-025 clr=1 in any state: next = IDLE, acc/cnt/ovf cleared, any simultaneous beat or out handshake discarded (clr wins).
REQ-026 cnt SHALL be $clog2(BURST_LEN+1) bits and never wrap.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_total=0, out_ovf=0, in_ready=0 while asserted.
REQ-028 Reset mid-burst SHALL discard the partial burst; in_ready=1 from the first clock edge after deassertion.

Configuration
REQ-029 Macro ACC_SATURATE_EN defined: on overflow acc SHALL clamp to 2^ACC_W-1 and hold there for the rest of the burst.
REQ-030 Macro ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf behaviour identical in both builds.

Structure
REQ-031 Package adder_acc_pkg SHALL hold the state enum (IDLE/ACCUM/HOLD), BEAT_W=5 and SUM_W=4 constants.
REQ-032 Single module, no sub-modules; the ripple-carry adder SHALL be instantiated only in benches, never inside this block.

Verification
REQ-033 ACC_W=8, BURST_LEN=4: beats (sum,carry) = (11,0),(13,0),(14,0),(11,0) -> out_valid next cycle, out_total=49, out_ovf=0.
REQ-034 ACC_W=6, four beats (15,1)=31: wrap build -> out_total=60, out_ovf=1; ACC_SATURATE_EN build -> out_total=63, out_ovf=1.
REQ-035 out_ready held 0 for 3 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no beat accepted; out_ready=1 -> IDLE next cycle.
REQ-036 in_valid gaps of 2 cycles between beats -> total unchanged vs. back-to-back (49), out_valid delayed accordingly.
REQ-037 clr=1 coincident with 3rd beat accept -> IDLE, next 4 beats of 5 yield out_total=20.
REQ-038 rst_n pulsed low after 2 beats -> all outputs 0 asynchronously; subsequent 4 beats of 1 yield out_total=4.
